// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and width helpers for the APB memory slave
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_RANGE,
    ERR_ALIGN,
    ERR_PROTO
  } apb_err_e;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int align_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// rtl/apb_mem_bank.sv - DEPTH x DATA_W byte-enabled register array, async clear
module apb_mem_bank
  import apb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int STRB_W = strb_w(DATA_W);
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Non-power-of-two depths leave index codes with no backing word.
  assign rd_data = ({1'b0, rd_idx} < DEPTH_L) ? mem[rd_idx] : '0;

endmodule

// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB4 memory slave: FSM, wait counter, error decode, output registers
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int STRB_W  = strb_w(DATA_W);
  localparam int ALIGN_W = align_w(DATA_W);
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);
  localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  WAIT_L     = CNT_W'(WAIT_CYCLES);

  apb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] prdata_q;
  logic              pready_q, pslverr_q;

  logic [ADDR_W-1:0] word_full;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] rd_data;
  apb_err_e          err_cause;
  logic              err_hit;
  logic              fire;
  logic              proto;
  logic              wr_en;

  assign word_full = paddr >> ALIGN_W;
  assign word_idx  = word_full[IDX_W-1:0];

  always_comb begin
    err_cause = ERR_NONE;
    if ((paddr & ALIGN_MASK) != '0)            err_cause = ERR_ALIGN;
    else if ({1'b0, word_full} >= DEPTH_L)     err_cause = ERR_RANGE;
  end

  assign err_hit = (err_cause != ERR_NONE);

  apb_mem_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk     (pclk),
    .rst_n   (presetn),
    .wr_en   (wr_en),
    .wr_idx  (word_idx),
    .wr_data (pwdata),
    .wr_strb (pstrb),
    .rd_idx  (word_idx),
    .rd_data (rd_data)
  );

  // Outputs are registered, so the response is decided one edge ahead:
  // fire means the coming cycle is the completion cycle. SETUP is the
  // first access-phase cycle and cnt_q counts access cycles already spent.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    proto   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = SETUP;
          cnt_d   = '0;
          fire    = (WAIT_L == '0);
        end else if (psel && penable) begin
          proto = 1'b1;
        end
      end
      SETUP, ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (pready_q) begin
          if (penable) begin
            state_d = IDLE;
            wr_en   = pwrite && !err_hit;
          end else begin
            state_d = SETUP;
            cnt_d   = '0;
            fire    = (WAIT_L == '0);
          end
        end else begin
          state_d = ACCESS;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          fire    = (cnt_d == WAIT_L);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= fire || proto;
      pslverr_q <= proto || (fire && err_hit);
      prdata_q  <= (fire && !pwrite && !err_hit) ? rd_data : '0;
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule
